axi4s_to_python: RTL



---
 rtl/axi4s_to_python.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/axi4s_to_python.sv
// Purpose : regenerate the PYTHON300 4x10-bit lane stream plus sync channel from a 4-pixel AXI4-Stream image.
// Latency : every output word is registered, appearing 1 cycle after its state cycle or accepted beat.
// Backpressure: s_axi4s_tready is high only in LINE; the output side has no backpressure (m_valid only).
// Optional: define AXI4S_TO_PYTHON_TRAINING_EN to flag IDLE/H-blank training words as valid.
module axi4s_to_python #(
    parameter int         BLACK_LINES = 1,
    parameter int         BLACK_WIDTH = 320,
    parameter int         HBLANK      = 67,
    parameter logic [9:0] BLACK_LEVEL = 10'h040
) (
    input  logic        reset,
    input  logic        clk,
    input  logic        cke,
    input  logic [1:0]  s_axi4s_tuser,
    input  logic        s_axi4s_tlast,
    input  logic [39:0] s_axi4s_tdata,
    input  logic        s_axi4s_tvalid,
    output logic        s_axi4s_tready,
    output logic [39:0] m_data,
    output logic [9:0]  m_sync,
    output logic        m_valid,
    output logic        err_short_line
);

    localparam int BL_W = $clog2((BLACK_LINES > 2) ? BLACK_LINES : 2);
    localparam int BW_W = $clog2((BLACK_WIDTH > 2) ? BLACK_WIDTH : 2);
    localparam int HB_W = $clog2((HBLANK > 2) ? HBLANK : 2);

    localparam logic [9:0] SYNC_TR  = 10'h3a6;
    localparam logic [9:0] SYNC_BLS = 10'h22a;
    localparam logic [9:0] SYNC_BL  = 10'h015;
    localparam logic [9:0] SYNC_BLE = 10'h12a;
    localparam logic [9:0] SYNC_FS  = 10'h2aa;
    localparam logic [9:0] SYNC_LS  = 10'h0aa;
    localparam logic [9:0] SYNC_PIX = 10'h035;
    localparam logic [9:0] SYNC_LE  = 10'h12a;
    localparam logic [9:0] SYNC_FE  = 10'h3aa;
    localparam logic [9:0] SYNC_CRC = 10'h059;

    localparam logic [39:0] TRAIN_DATA = {4{SYNC_TR}};
    localparam logic [39:0] BLACK_DATA = {4{BLACK_LEVEL}};

`ifdef AXI4S_TO_PYTHON_TRAINING_EN
    localparam logic TRAIN_VLD = 1'b1;
`else
    localparam logic TRAIN_VLD = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLACK,
        S_B_CRC,
        S_B_HBLANK,
        S_LINE,
        S_CRC,
        S_HBLANK
    } state_t;

    state_t          r_state;
    logic [BL_W-1:0] r_lcnt;
    logic [BW_W-1:0] r_bcnt;
    logic [HB_W-1:0] r_hcnt;
    logic            r_start;
    logic            r_tready;
    logic            r_valid;
    logic [9:0]      r_sync;
    logic [39:0]     r_data;
    logic            r_err;

    logic w_black_last;
    logic w_hblank_last;
    logic w_more_black;

    assign w_black_last  = (int'(r_bcnt) == BLACK_WIDTH - 1);
    assign w_hblank_last = (int'(r_hcnt) == HBLANK - 1);
    // line_cnt is bumped on the same edge, so look one ahead
    assign w_more_black  = (int'(r_lcnt) + 1 < BLACK_LINES);

    assign s_axi4s_tready = r_tready;
    assign m_valid        = r_valid;
    assign m_sync         = r_sync;
    assign m_data         = r_data;
    assign err_short_line = r_err;

    // Frame sequencer: walks black lines, image lines, CRC slots and H-blank, registering every output word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_lcnt   <= '0;
            r_bcnt   <= '0;
            r_hcnt   <= '0;
            r_start  <= 1'b0;
            r_tready <= 1'b0;
            r_valid  <= 1'b0;
            r_sync   <= SYNC_TR;
            r_data   <= '0;
            r_err    <= 1'b0;
        end else if (cke) begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_valid <= TRAIN_VLD;
                    r_sync  <= SYNC_TR;
                    r_data  <= TRAIN_DATA;
                    // the waiting beat is only peeked here; it is consumed in LINE
                    if (s_axi4s_tvalid) begin
                        if (s_axi4s_tuser[0] && (BLACK_LINES > 0)) begin
                            r_state <= S_BLACK;
                            r_lcnt  <= '0;
                            r_bcnt  <= '0;
                        end else begin
                            r_state  <= S_LINE;
                            r_tready <= 1'b1;
                            r_start  <= 1'b1;
                        end
                    end
                end
                S_BLACK: begin
                    r_valid <= 1'b1;
                    r_data  <= BLACK_DATA;
                    if (r_bcnt == '0)
                        r_sync <= SYNC_BLS;
                    else if (w_black_last)
                        r_sync <= SYNC_BLE;
                    else
                        r_sync <= SYNC_BL;
                    if (w_black_last) begin
                        r_bcnt  <= '0;
                        r_state <= S_B_CRC;
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                S_B_CRC: begin
                    r_valid <= 1'b1;
                    r_sync  <= SYNC_CRC;
                    r_data  <= '0;
                    if (HBLANK > 0) begin
                        r_state <= S_B_HBLANK;
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                        if (w_more_black) begin
                            r_state <= S_BLACK;
                        end else begin
                            r_state  <= S_LINE;
                            r_tready <= 1'b1;
                            r_start  <= 1'b1;
                        end
                    end
                end
                S_B_HBLANK: begin
                    r_valid <= TRAIN_VLD;
                    r_sync  <= SYNC_TR;
                    r_data  <= TRAIN_DATA;
                    if (w_hblank_last) begin
                        r_hcnt <= '0;
                        r_lcnt <= r_lcnt + 1'b1;
                        if (w_more_black) begin
                            r_state <= S_BLACK;
                        end else begin
                            r_state  <= S_LINE;
                            r_tready <= 1'b1;
                            r_start  <= 1'b1;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_LINE: begin
                    if (s_axi4s_tvalid) begin
                        r_valid <= 1'b1;
                        r_data  <= s_axi4s_tdata;
                        r_start <= 1'b0;
                        // a single-beat line keeps its start code and drops LE/FE
                        if (r_start) begin
                            r_sync <= s_axi4s_tuser[0] ? SYNC_FS : SYNC_LS;
                            r_err  <= s_axi4s_tlast;
                        end else if (s_axi4s_tlast) begin
                            r_sync <= s_axi4s_tuser[1] ? SYNC_FE : SYNC_LE;
                        end else begin
                            r_sync <= SYNC_PIX;
                        end
                        if (s_axi4s_tlast) begin
                            r_state  <= S_CRC;
                            r_tready <= 1'b0;
                        end
                    end else begin
                        // stalled input: no word this cycle, start flag is retained
                        r_valid <= 1'b0;
                    end
                end
                S_CRC: begin
                    r_valid <= 1'b1;
                    r_sync  <= SYNC_CRC;
                    r_data  <= '0;
                    r_state <= (HBLANK > 0) ? S_HBLANK : S_IDLE;
                end
                S_HBLANK: begin
                    r_valid <= TRAIN_VLD;
                    r_sync  <= SYNC_TR;
                    r_data  <= TRAIN_DATA;
                    if (w_hblank_last) begin
                        r_hcnt  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_tready <= 1'b0;
                    r_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
